// File: rtl/uart_dec_sender_if.sv
// TX FIFO push bus between the decimal sender and the UART controller.
// master: drives push/push_data, samples full. slave: the FIFO side.
interface uart_dec_sender_if;
  logic       push;
  logic [7:0] push_data;
  logic       full;

  modport master (
    output push,
    output push_data,
    input  full
  );

  modport slave (
    input  push,
    input  push_data,
    output full
  );
endinterface

// File: rtl/uart_dec_sender.sv
// Decimal-to-ASCII sender: double-dabble BCD conversion, then pushes
// DIGITS ASCII digits (MSD first), optional zero suppression and CR/LF.
// Ports: clk, rst (async, high); i_start/i_data request;
//   tx (master): push strobe, push_data byte, full backpressure;
//   o_busy (CONV/SEND), o_done (1-cycle), o_ovf (value >= 10**DIGITS).
module uart_dec_sender #(
  parameter int DATA_W      = 10,
  parameter int DIGITS      = 3,
  parameter int LZ_SUPPRESS = 0,
  parameter int APPEND_CRLF = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  uart_dec_sender_if.master tx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);

  // Decimal digits needed to hold 2**DATA_W-1.
  function automatic int bcd_digits(input int w);
    longint unsigned lim;
    longint unsigned p;
    int n;
    lim = (64'd1 << w) - 64'd1;
    p = 64'd1;
    n = 0;
    for (int k = 0; k < 11; k++) begin
      if (p <= lim) begin
        p = p * 64'd10;
        n++;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  localparam int BCD_DIG = bcd_digits(DATA_W);
  localparam int NBCD = (BCD_DIG > DIGITS) ? BCD_DIG : DIGITS;
  localparam int W4 = 4 * NBCD;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);
  localparam logic [3:0] LAST_DIG = 4'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_DIG,
    PH_CR,
    PH_LF
  } phase_e;

  function automatic logic [3:0] dig_at(
    input logic [W4-1:0] v,
    input logic [3:0]    i
  );
    dig_at = '0;
    for (int k = 0; k < NBCD; k++) begin
      if (i == 4'(k)) dig_at = v[4*k +: 4];
    end
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  state_e            state_q, state_d;
  phase_e            ph_q, ph_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [W4-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [W4-1:0]     adj;
  logic [W4-1:0]     bcd_nx;
  logic              hi_ovf;
  logic [3:0]        lead;
  logic [3:0]        nxt_idx;
  logic              push;

  assign push         = (state_q == S_SEND) && !tx.full;
  assign tx.push      = push;
  assign tx.push_data = data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_ovf        = ovf_q;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    // One double-dabble step: add 3 to nibbles >= 5, then shift in MSB.
    adj = bcd_q;
    for (int k = 0; k < NBCD; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_nx = {adj[W4-2:0], sh_q[DATA_W-1]};

    hi_ovf = 1'b0;
    for (int k = DIGITS; k < NBCD; k++) begin
      if (bcd_nx[4*k +: 4] != 4'd0) hi_ovf = 1'b1;
    end

    // Highest nonzero emitted digit, or 0 when all are zero.
    lead = LAST_DIG;
    if (LZ_SUPPRESS != 0) begin
      lead = '0;
      for (int k = 0; k < DIGITS; k++) begin
        if (bcd_nx[4*k +: 4] != 4'd0) lead = 4'(k);
      end
    end

    nxt_idx = idx_q - 4'd1;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CONV;
          sh_d    = i_data;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          ph_d    = PH_DIG;
        end
      end
      S_CONV: begin
        bcd_d = bcd_nx;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_SEND;
          ovf_d   = hi_ovf;
          idx_d   = lead;
          data_d  = asc(dig_at(bcd_nx, lead));
        end
      end
      S_SEND: begin
        if (push) begin
          unique case (1'b1)
            (ph_q == PH_DIG) && (idx_q != 4'd0): begin
              idx_d  = nxt_idx;
              data_d = asc(dig_at(bcd_q, nxt_idx));
            end
            (ph_q == PH_DIG) && (idx_q == 4'd0) &&
            (APPEND_CRLF != 0): begin
              ph_d   = PH_CR;
              data_d = 8'h0D;
            end
            (ph_q == PH_CR): begin
              ph_d   = PH_LF;
              data_d = 8'h0A;
            end
            default: begin
              state_d = S_DONE;
              ph_d    = PH_DIG;
              data_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= PH_DIG;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_dec_sender.sv
// Bench for uart_dec_sender: three configurations share clk/rst;
// per-instance scoreboard queues hold expected bytes and a done token.
module tb_uart_dec_sender;

  logic clk;
  logic rst;
  logic [2:0] start;
  logic [2:0] full;
  logic [2:0][9:0] din;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] ovf;
  logic [2:0] push;
  logic [2:0][7:0] pdat;

  logic [8:0] exp_q [3][$];
  int n_chk;
  int n_fail;

  uart_dec_sender_if if_a ();
  uart_dec_sender_if if_b ();
  uart_dec_sender_if if_c ();

  assign if_a.full = full[0];
  assign if_b.full = full[1];
  assign if_c.full = full[2];
  assign push[0] = if_a.push;
  assign push[1] = if_b.push;
  assign push[2] = if_c.push;
  assign pdat[0] = if_a.push_data;
  assign pdat[1] = if_b.push_data;
  assign pdat[2] = if_c.push_data;

  uart_dec_sender #(.DATA_W(10), .DIGITS(3),
                    .LZ_SUPPRESS(0), .APPEND_CRLF(0)) u_a (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_data(din[0]),
    .tx(if_a.master), .o_busy(busy[0]), .o_done(done[0]),
    .o_ovf(ovf[0]));

  uart_dec_sender #(.DATA_W(10), .DIGITS(3),
                    .LZ_SUPPRESS(1), .APPEND_CRLF(0)) u_b (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_data(din[1]),
    .tx(if_b.master), .o_busy(busy[1]), .o_done(done[1]),
    .o_ovf(ovf[1]));

  uart_dec_sender #(.DATA_W(10), .DIGITS(2),
                    .LZ_SUPPRESS(0), .APPEND_CRLF(1)) u_c (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_data(din[2]),
    .tx(if_c.master), .o_busy(busy[2]), .o_done(done[2]),
    .o_ovf(ovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int digs_of(input int i);
    return (i == 2) ? 2 : 3;
  endfunction

  function automatic bit lz_of(input int i);
    return i == 1;
  endfunction

  function automatic bit crlf_of(input int i);
    return i == 2;
  endfunction

  function automatic int pw10(input int d);
    int p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  task automatic expect_msg(input int i, input int v);
    int d[10];
    int m;
    int top;
    m = v;
    for (int k = 0; k < 10; k++) begin
      d[k] = m % 10;
      m = m / 10;
    end
    top = digs_of(i) - 1;
    if (lz_of(i)) begin
      while (top > 0 && d[top] == 0) top--;
    end
    for (int k = top; k >= 0; k--) begin
      exp_q[i].push_back(9'(8'h30 + d[k]));
    end
    if (crlf_of(i)) begin
      exp_q[i].push_back(9'h00D);
      exp_q[i].push_back(9'h00A);
    end
    exp_q[i].push_back(9'h100);
  endtask

  task automatic sb_pop(input int i, input logic [8:0] got);
    if (exp_q[i].size() == 0) begin
      check($sformatf("unexpected_out%0d", i), 32'(got), 32'h1FF);
    end else begin
      check($sformatf("sb_out%0d", i), 32'(got),
            32'(exp_q[i].pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) sb_pop(i, {1'b0, pdat[i]});
        if (done[i]) sb_pop(i, 9'h100);
        if (busy[i] && done[i]) begin
          check($sformatf("busy_and_done%0d", i), 32'd1, 32'd0);
        end
        if (full[i]) begin
          check($sformatf("push_while_full%0d", i),
                32'(push[i]), 32'd0);
        end
      end
    end
  end

  task automatic run(input int i, input int v,
                     input int exp_lat, input int exp_gap);
    int n;
    @(negedge clk);
    start[i] = 1'b1;
    din[i] = 10'(v);
    expect_msg(i, v);
    @(negedge clk);
    start[i] = 1'b0;
    din[i] = 10'($urandom);
    check("busy_after_accept", 32'(busy[i]), 32'd1);
    check("ovf_cleared", 32'(ovf[i]), 32'd0);
    n = 1;
    while (!push[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_lat >= 0) check("first_push_latency", n, exp_lat);
    n = 0;
    while (!done[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done[i]), 32'd1);
    if (exp_gap >= 0) check("push_to_done", n, exp_gap);
    check("busy_low_at_done", 32'(busy[i]), 32'd0);
    check("ovf_flag", 32'(ovf[i]), 32'(v >= pw10(digs_of(i))));
  endtask

  task automatic wait_push(input int i);
    int n;
    n = 0;
    while (!push[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_seen", 32'(push[i]), 32'd1);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (!done[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done[i]), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_push"}, 32'(push[i]), 32'd0);
      check({tag, "_data"}, 32'(pdat[i]), 32'd0);
      check({tag, "_busy"}, 32'(busy[i]), 32'd0);
      check({tag, "_done"}, 32'(done[i]), 32'd0);
      check({tag, "_ovf"}, 32'(ovf[i]), 32'd0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start = '0;
    full = '0;
    din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Basic value, latency and consecutive bytes.
    run(0, 123, 11, 3);
    // Zero padding and suppression.
    run(0, 7, 11, 3);
    run(1, 7, 11, 1);
    run(1, 0, 11, 1);
    run(1, 1000, 11, 1);
    // Overflow, then cleared by the next start.
    run(0, 1023, 11, 3);
    run(0, 5, 11, 3);
    run(2, 45, 11, 4);

    // Backpressure after the first byte.
    @(negedge clk);
    start[2] = 1'b1;
    din[2] = 10'd45;
    expect_msg(2, 45);
    @(negedge clk);
    start[2] = 1'b0;
    wait_push(2);
    @(posedge clk);
    #1 full[2] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_no_push", 32'(push[2]), 32'd0);
    end
    full[2] = 1'b0;
    wait_done(2);

    // Starts during CONV and SEND are ignored.
    @(negedge clk);
    start[0] = 1'b1;
    din[0] = 10'd456;
    expect_msg(0, 456);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    din[0] = 10'd999;
    @(negedge clk);
    start[0] = 1'b0;
    wait_push(0);
    start[0] = 1'b1;
    din[0] = 10'd888;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    // Back-to-back start in the IDLE cycle after done.
    run(0, 789, 11, 3);
    run(2, 3, 11, 4);
    run(2, 99, 11, 4);
    repeat (30) @(negedge clk);

    // Reset in the middle of a message.
    @(negedge clk);
    start[0] = 1'b1;
    din[0] = 10'd321;
    expect_msg(0, 321);
    @(negedge clk);
    start[0] = 1'b0;
    wait_push(0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q[0].delete();
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run(0, 42, 11, 3);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sb_empty%0d", i), exp_q[i].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
